// File: rtl/axis_seq_receiver_pkg.sv
// Purpose: shared sizing defaults and receiver state encoding for axis_seq_receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: SEQ_N / SEQ_CHAR_LEN / SEQ_PAD_CHAR defaults, rx_state_e (R_IDLE..R_DONE).
package axis_seq_receiver_pkg;

  localparam int SEQ_N        = 4;   // characters per sequence
  localparam int SEQ_CHAR_LEN = 8;   // bits per character
  localparam int SEQ_PAD_CHAR = 0;   // code written into unfilled slots

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_RECV = 2'd1,
    R_DROP = 2'd2,
    R_DONE = 2'd3
  } rx_state_e;

endpackage

// File: rtl/seq_slot_writer.sv
// Purpose: N-slot character register file with clear-to-PAD and single indexed write.
// Latency: one cycle from clr_i/wr_i to q_o.
// Backpressure: none; accepts a write every cycle.
// Ports: clk, rst (async high) | clr_i loads PAD_CHAR into every slot (wins over wr_i) |
//        wr_i/idx_i/dat_i write one slot | q_o packed slots, slot i at [i*CHAR_LEN +: CHAR_LEN].
module seq_slot_writer #(
  parameter int                  N        = 4,
  parameter int                  CHAR_LEN = 8,
  parameter logic [CHAR_LEN-1:0] PAD_CHAR = '0,
  localparam int                 CW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    wr_i,
  input  logic [CW-1:0]           idx_i,
  input  logic [CHAR_LEN-1:0]     dat_i,
  output logic [N*CHAR_LEN-1:0]   q_o
);

  for (genvar i = 0; i < N; i++) begin : g_slot
    logic [CHAR_LEN-1:0] slot_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        slot_q <= '0;
      end else if (clr_i) begin
        slot_q <= PAD_CHAR;
      end else if (wr_i && (idx_i == CW'(i))) begin
        slot_q <= dat_i;
      end
    end

    assign q_o[i*CHAR_LEN +: CHAR_LEN] = slot_q;
  end

endmodule

// File: rtl/axis_seq_receiver.sv
// Purpose: collect one AXI-Stream character sequence into a packed N-slot vector with length/overflow.
// Latency: tready one cycle after run rises; valid one cycle after the tlast handshake; 1 beat/cycle.
// Backpressure: tready decodes RECV|DROP only; beats beyond N are accepted and dropped until tlast.
// Ports: clk, rst (async high), run (level request) | s_axis_tdata/tlast/tvalid/tready slave |
//        valid, q, len, overflow (registered, stable while valid).
module axis_seq_receiver
  import axis_seq_receiver_pkg::*;
#(
  parameter int                  N        = SEQ_N,
  parameter int                  CHAR_LEN = SEQ_CHAR_LEN,
  parameter logic [CHAR_LEN-1:0] PAD_CHAR = CHAR_LEN'(SEQ_PAD_CHAR),
  localparam int                 CW       = (N > 1) ? $clog2(N) : 1,
  localparam int                 LW       = $clog2(N + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [CHAR_LEN-1:0]   s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  valid,
  output logic [N*CHAR_LEN-1:0] q,
  output logic [LW-1:0]         len,
  output logic                  overflow
);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic          valid_q;
  logic          clr, wr, hs;

  assign s_axis_tready = (state_q == R_RECV) || (state_q == R_DROP);
  assign hs            = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= R_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      // Registered decode of the next state keeps valid glitch-free and
      // drops it on the same edge that leaves DONE.
      valid_q <= (state_d == R_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    clr     = 1'b0;
    wr      = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        if (run) begin
          state_d = R_RECV;
          clr     = 1'b1;
          cnt_d   = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      R_RECV: begin
        // Losing run aborts; a beat handshaken in this cycle is discarded.
        if (!run) begin
          state_d = R_IDLE;
        end else if (hs) begin
          wr    = 1'b1;
          len_d = len_q + LW'(1);
          if (s_axis_tlast) begin
            state_d = R_DONE;
          end else if (cnt_q == CW'(N - 1)) begin
            state_d = R_DROP;
            ovf_d   = 1'b1;
          end
          // Counter stops at N-1: every path out of the last slot leaves RECV.
          if (cnt_q != CW'(N - 1)) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      R_DROP: begin
        if (!run) begin
          state_d = R_IDLE;
        end else if (hs && s_axis_tlast) begin
          state_d = R_DONE;
        end
      end
      R_DONE: begin
        if (!run) begin
          state_d = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  seq_slot_writer #(
    .N        (N),
    .CHAR_LEN (CHAR_LEN),
    .PAD_CHAR (PAD_CHAR)
  ) u_slots (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .wr_i  (wr),
    .idx_i (cnt_q),
    .dat_i (s_axis_tdata),
    .q_o   (q)
  );

  assign valid    = valid_q;
  assign len      = len_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_axis_seq_receiver.sv
module tb_axis_seq_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [7:0]  tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic        valid;
  logic [31:0] q;
  logic [2:0]  len;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  axis_seq_receiver #(
    .N        (4),
    .CHAR_LEN (8),
    .PAD_CHAR (8'h00)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .s_axis_tdata  (tdata),
    .s_axis_tlast  (tlast),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .valid         (valid),
    .q             (q),
    .len           (len),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample/drive 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; tdata = 8'h00; tlast = 1'b0; tvalid = 1'b0;
    #12;
    chk("rst_tready",   {31'd0, tready},   32'd0);
    chk("rst_valid",    {31'd0, valid},    32'd0);
    chk("rst_q",        q,                 32'd0);
    chk("rst_len",      {29'd0, len},      32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick();

    // Full sequence, tlast exactly on beat N.
    run = 1'b1;
    tick();
    chk("full_tready_after_run", {31'd0, tready}, 32'd1);
    beat(8'h41, 1'b0);
    beat(8'h42, 1'b0);
    beat(8'h43, 1'b0);
    chk("full_valid_before_last", {31'd0, valid}, 32'd0);
    beat(8'h44, 1'b1);
    chk("full_valid",    {31'd0, valid},    32'd1);
    chk("full_q",        q,                 32'h44434241);
    chk("full_len",      {29'd0, len},      32'd4);
    chk("full_overflow", {31'd0, overflow}, 32'd0);
    chk("full_tready_done", {31'd0, tready}, 32'd0);
    // tvalid during DONE must not be accepted.
    beat(8'h55, 1'b1);
    chk("done_hold_q",     q,              32'h44434241);
    chk("done_hold_valid", {31'd0, valid}, 32'd1);
    run = 1'b0;
    tick();
    chk("full_valid_fall",  {31'd0, valid},  32'd0);
    chk("idle_tready",      {31'd0, tready}, 32'd0);
    // tvalid during IDLE without run: nothing accepted, q untouched.
    beat(8'h66, 1'b0);
    chk("idle_no_accept_q", q, 32'h44434241);

    // Early tlast with gapped tvalid; first beat offered together with run.
    run = 1'b1; tvalid = 1'b1; tdata = 8'h0A; tlast = 1'b0;
    tick();
    chk("early_cleared_q",   q,               32'h00000000);
    chk("early_len_cleared", {29'd0, len},    32'd0);
    chk("early_tready",      {31'd0, tready}, 32'd1);
    tick();
    chk("early_first_accept", q, 32'h0000000A);
    tvalid = 1'b0; tdata = 8'hEE; tlast = 1'b1;
    tick();
    chk("early_gap_len", {29'd0, len}, 32'd1);
    chk("early_gap_q",   q,            32'h0000000A);
    beat(8'h0B, 1'b1);
    tvalid = 1'b0;
    chk("early_valid", {31'd0, valid}, 32'd1);
    chk("early_q",     q,              32'h00000B0A);
    chk("early_len",   {29'd0, len},   32'd2);
    tick();
    chk("early_valid_held", {31'd0, valid}, 32'd1);
    run = 1'b0;
    tick();
    chk("early_valid_fall", {31'd0, valid}, 32'd0);

    // Overflow: six beats into four slots.
    run = 1'b1;
    tick();
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b0);
    beat(8'h04, 1'b0);
    chk("ovf_flag_at_drop", {31'd0, overflow}, 32'd1);
    chk("ovf_tready_drop",  {31'd0, tready},   32'd1);
    chk("ovf_valid_drop",   {31'd0, valid},    32'd0);
    beat(8'h05, 1'b0);
    chk("ovf_drop_q", q, 32'h04030201);
    beat(8'h06, 1'b1);
    tvalid = 1'b0; tlast = 1'b0;
    chk("ovf_valid",    {31'd0, valid},    32'd1);
    chk("ovf_q",        q,                 32'h04030201);
    chk("ovf_len",      {29'd0, len},      32'd4);
    chk("ovf_overflow", {31'd0, overflow}, 32'd1);
    run = 1'b0;
    tick();

    // Abort after two beats; beat offered in the abort cycle is discarded.
    run = 1'b1;
    tick();
    beat(8'h11, 1'b0);
    beat(8'h12, 1'b0);
    run = 1'b0; tvalid = 1'b1; tdata = 8'h13; tlast = 1'b0;
    tick();
    tvalid = 1'b0;
    chk("abort_tready",  {31'd0, tready}, 32'd0);
    chk("abort_valid",   {31'd0, valid},  32'd0);
    chk("abort_q_kept",  q,               32'h00001211);
    chk("abort_len",     {29'd0, len},    32'd2);
    tick();
    chk("abort_valid_later", {31'd0, valid}, 32'd0);
    run = 1'b1; tvalid = 1'b1; tdata = 8'h7F; tlast = 1'b1;
    tick();
    chk("abort_rerun_cleared", q, 32'h00000000);
    tick();
    tvalid = 1'b0; tlast = 1'b0;
    chk("single_valid",    {31'd0, valid},    32'd1);
    chk("single_q",        q,                 32'h0000007F);
    chk("single_len",      {29'd0, len},      32'd1);
    chk("single_overflow", {31'd0, overflow}, 32'd0);
    run = 1'b0;
    tick();

    // Async reset between edges while a beat is held.
    run = 1'b1;
    tick();
    beat(8'h21, 1'b0);
    tvalid = 1'b1; tdata = 8'h22; tlast = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tready",   {31'd0, tready},   32'd0);
    chk("arst_valid",    {31'd0, valid},    32'd0);
    chk("arst_q",        q,                 32'd0);
    chk("arst_len",      {29'd0, len},      32'd0);
    chk("arst_overflow", {31'd0, overflow}, 32'd0);
    run = 1'b0;
    tick();
    chk("arst_held_q", q, 32'd0);
    #2;
    rst = 1'b0;
    tick();
    chk("arst_after_tready", {31'd0, tready}, 32'd0);
    chk("arst_after_q",      q,               32'd0);
    tvalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
